// File: rtl/nested_loop_counter.sv
// nested_loop_counter: LEVELS nested loop indices, innermost advances on adv,
// outer levels advance on carry; one-shot or continuous passes with abort.
module nested_loop_counter #(
   parameter int LEVELS    = 3,
   parameter int CNT_WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [LEVELS*CNT_WIDTH-1:0]   cfg_max,
   input  logic                          cfg_loop,
   input  logic                          start,
   input  logic                          abort,
   input  logic                          adv,
   output logic                          busy,
   output logic [LEVELS*CNT_WIDTH-1:0]   cnt,
   output logic [LEVELS-1:0]             at_max,
   output logic [LEVELS-1:0]             wrap,
   output logic                          last,
   output logic                          done
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state;
   logic [CNT_WIDTH-1:0] max_q [LEVELS];
   logic [CNT_WIDTH-1:0] cnt_q [LEVELS];
   logic                 loop_q;
   logic                 done_q;
   logic [LEVELS-1:0]    inc;

   assign busy = (state == RUN);
   assign last = wrap[LEVELS-1];
   assign done = done_q;

   // inc[k]: level k steps this cycle; carry ripples through levels at max
   for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
      assign cnt[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k];
      assign at_max[k] = (cnt_q[k] == max_q[k]);
      if (k == 0) begin : g_in
         assign inc[k] = busy & adv;
      end else begin : g_out
         assign inc[k] = inc[k-1] & at_max[k-1];
      end
      assign wrap[k] = inc[k] & at_max[k];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         loop_q <= 1'b0;
         done_q <= 1'b0;
         for (int k = 0; k < LEVELS; k++) begin
            max_q[k] <= '0;
            cnt_q[k] <= '0;
         end
      end else if (abort) begin
         state  <= IDLE;
         done_q <= 1'b0;
         for (int k = 0; k < LEVELS; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         unique case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  loop_q <= cfg_loop;
                  state  <= RUN;
                  for (int k = 0; k < LEVELS; k++) begin
                     max_q[k] <= cfg_max[k*CNT_WIDTH +: CNT_WIDTH];
                     cnt_q[k] <= '0;
                  end
               end
            end
            RUN: begin
               done_q <= last;
               for (int k = 0; k < LEVELS; k++) begin
                  if (inc[k]) begin
                     cnt_q[k] <= at_max[k] ? '0
                                           : cnt_q[k] + CNT_WIDTH'(1);
                  end
               end
               if (last && !loop_q) begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nested_loop_counter.sv
// Directed bench for nested_loop_counter: LEVELS=3, CNT_WIDTH=4,
// expected values computed by hand or from the loop index.
module tb_nested_loop_counter;

   localparam int L = 3;
   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [L*W-1:0] cfg_max = '0;
   logic           cfg_loop = 1'b0;
   logic           start = 1'b0;
   logic           abort = 1'b0;
   logic           adv = 1'b0;
   logic           busy;
   logic [L*W-1:0] cnt;
   logic [L-1:0]   at_max;
   logic [L-1:0]   wrap;
   logic           last;
   logic           done;

   int n_cmp = 0;
   int n_err = 0;

   nested_loop_counter #(.LEVELS(L), .CNT_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .cfg_max(cfg_max), .cfg_loop(cfg_loop),
      .start(start), .abort(abort), .adv(adv), .busy(busy), .cnt(cnt),
      .at_max(at_max), .wrap(wrap), .last(last), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // one edge, then settle 1 time unit past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set(input logic s, input logic a, input logic ab);
      start = s;
      adv   = a;
      abort = ab;
   endtask

   task automatic do_start(input logic [L*W-1:0] m, input logic lp);
      cfg_max  = m;
      cfg_loop = lp;
      set(1, 0, 0);
      tick();
      set(0, 0, 0);
   endtask

   // pack a linear pass index into {l2,l1,l0} for bounds {2,1,3}
   function automatic logic [31:0] idx213(input int i);
      return ((i / 8) << 8) | (((i / 4) % 2) << 4) | (i % 4);
   endfunction

   initial begin
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_done", done, 0);
      chk("rst_atmax", at_max, 3'b111);
      chk("rst_wrap", wrap, 0);
      #4 rst = 1'b0;
      tick();

      // basic one-shot {2,1,3}, adv held
      do_start(12'h213, 0);
      chk("t1_busy", busy, 1);
      chk("t1_cnt0", cnt, 0);
      for (int i = 0; i < 24; i++) begin
         set(0, 1, 0);
         #1;
         chk("t1_cnt", cnt, idx213(i));
         chk("t1_wrap0", wrap[0], (i % 4) == 3);
         chk("t1_wrap1", wrap[1], (i % 8) == 7);
         chk("t1_last", last, i == 23);
         chk("t1_nodone", done, 0);
         tick();
      end
      set(0, 0, 0);
      chk("t1_done", done, 1);
      chk("t1_busy_fall", busy, 0);
      chk("t1_cnt_end", cnt, 0);
      tick();
      chk("t1_done_once", done, 0);

      // gapped adv: 24 advs over 47 cycles
      do_start(12'h213, 0);
      for (int j = 0; j < 47; j++) begin
         set(0, (j % 2) == 0, 0);
         #1;
         chk("t2_cnt", cnt, idx213((j + 1) / 2));
         chk("t2_last", last, j == 46);
         chk("t2_nodone", done, 0);
         tick();
      end
      set(0, 0, 0);
      chk("t2_done", done, 1);
      chk("t2_busy", busy, 0);

      // degenerate bounds {0,0,5}: six-adv pass
      do_start(12'h005, 0);
      chk("t3_atmax21", at_max[2:1], 2'b11);
      for (int i = 0; i < 6; i++) begin
         set(0, 1, 0);
         #1;
         chk("t3_atmax21_run", at_max[2:1], 2'b11);
         chk("t3_last", last, i == 5);
         tick();
      end
      set(0, 0, 0);
      chk("t3_done", done, 1);

      // full-range L0=15 carries into L1
      do_start(12'h01F, 0);
      set(0, 1, 0);
      for (int i = 0; i < 15; i++) tick();
      chk("t3_cnt_f", cnt, 12'h00F);
      chk("t3_wrap0", wrap, 3'b001);
      chk("t3_nolast", last, 0);
      tick();
      set(0, 0, 0);
      chk("t3_carry", cnt, 12'h010);
      set(0, 0, 1);
      tick();
      set(0, 0, 0);
      chk("t3_abort", busy, 0);

      // continuous {0,1,1}, abort at adv #10
      do_start(12'h011, 1);
      for (int i = 1; i <= 9; i++) begin
         set(0, 1, 0);
         tick();
         chk("t4_done", done, (i % 4) == 0);
         chk("t4_busy", busy, 1);
      end
      set(0, 1, 1);
      tick();
      chk("t4_ab_busy", busy, 0);
      chk("t4_ab_cnt", cnt, 0);
      for (int i = 11; i <= 13; i++) begin
         set(0, 1, 0);
         tick();
         chk("t4_nodone", done, 0);
         chk("t4_idle", busy, 0);
      end
      set(0, 0, 0);

      // start+abort in IDLE stays IDLE
      cfg_max = 12'h213;
      set(1, 0, 1);
      tick();
      set(0, 0, 0);
      chk("t5_sa", busy, 0);

      // start during RUN with new bounds is ignored
      do_start(12'h213, 0);
      cfg_max = 12'h000;
      set(1, 0, 0);
      tick();
      set(0, 0, 0);
      chk("t5_run_busy", busy, 1);
      chk("t5_run_atmax", at_max, 3'b000);
      set(0, 0, 1);
      tick();
      set(0, 0, 0);

      // abort in the last cycle
      do_start(12'h001, 0);
      set(0, 1, 0);
      tick();
      set(0, 1, 1);
      #1;
      chk("t5_ab_last", last, 1);
      tick();
      set(0, 0, 0);
      chk("t5_ab_done", done, 0);
      chk("t5_ab_busy", busy, 0);
      tick();
      chk("t5_ab_done2", done, 0);

      // start in the done cycle
      do_start(12'h001, 0);
      set(0, 1, 0);
      tick();
      tick();
      cfg_max = 12'h003;
      set(1, 0, 0);
      #1;
      chk("t5_b2b_done", done, 1);
      chk("t5_b2b_idle", busy, 0);
      tick();
      set(0, 0, 0);
      chk("t5_b2b_busy", busy, 1);
      chk("t5_b2b_at0", at_max[0], 0);
      set(0, 1, 0);
      for (int i = 0; i < 3; i++) tick();
      #1;
      chk("t5_b2b_last", last, 1);
      tick();
      set(0, 0, 0);
      chk("t5_b2b_done2", done, 1);

      // reset mid-run at cnt=112
      do_start(12'h213, 0);
      set(0, 1, 0);
      for (int i = 0; i < 14; i++) tick();
      set(0, 0, 0);
      chk("t6_cnt", cnt, 12'h112);
      #2 rst = 1'b1;
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_cnt0", cnt, 0);
      chk("t6_atmax", at_max, 3'b111);
      tick();
      chk("t6_nodone", done, 0);
      #2 rst = 1'b0;
      tick();
      do_start(12'h001, 0);
      chk("t6_restart", busy, 1);
      set(0, 1, 0);
      tick();
      tick();
      set(0, 0, 0);
      chk("t6_done", done, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
